// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with busy stall, one-cycle done pulse and flush abort.
module rv_muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int RF_ADDRESS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [XLEN-1:0]       op_a,
    input  logic [XLEN-1:0]       op_b,
    input  logic [RF_ADDRESS-1:0] rd_in,
    output logic                  busy,
    output logic                  done,
    output logic [XLEN-1:0]       result,
    output logic [RF_ADDRESS-1:0] rd_out
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam int XLEN2 = 2 * XLEN;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] x, input logic neg);
        return neg ? (~x + XLEN'(1)) : x;
    endfunction

    function automatic logic [XLEN2-1:0] neg_2x(input logic [XLEN2-1:0] x, input logic neg);
        return neg ? (~x + XLEN2'(1)) : x;
    endfunction

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [XLEN-1:0]       acc_hi, acc_lo, b_mag;
    logic [2:0]            op_q;
    logic                  neg_res, neg_rem;
    logic [RF_ADDRESS-1:0] rd_q;

    logic            is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag_in, b_mag_in, special_res;
    logic [XLEN:0]   mul_sum, div_shift;
    logic            div_ok;
    logic [XLEN-1:0] rem_next, quo_next, quo_fin, rem_fin;
    logic [XLEN2-1:0] prod_next, prod_fin;

    // Operand decode: which operands are signed, and the divide special cases
    always_comb begin
        is_div   = funct3[2];
        a_sgn    = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        b_sgn    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg    = a_sgn && op_a[XLEN-1];
        b_neg    = b_sgn && op_b[XLEN-1];
        a_mag_in = neg_x(op_a, a_neg);
        b_mag_in = neg_x(op_b, b_neg);
        div_zero = is_div && (op_b == '0);
        div_ovf  = is_div && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
        if (div_zero)
            special_res = funct3[1] ? op_a : '1;
        else
            special_res = funct3[1] ? '0 : op_a;
    end

    // One iteration step: multiply adds into the high half and shifts right,
    // divide shifts the dividend into the partial remainder and trial-subtracts.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : '0);
        prod_next = {mul_sum, acc_lo[XLEN-1:1]};
        prod_fin  = neg_2x(prod_next, neg_res);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_ok    = div_shift >= {1'b0, b_mag};
        rem_next  = div_ok ? (div_shift[XLEN-1:0] - b_mag) : div_shift[XLEN-1:0];
        quo_next  = {acc_lo[XLEN-2:0], div_ok};
        quo_fin   = neg_x(quo_next, neg_res);
        rem_fin   = neg_x(rem_next, neg_rem);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            b_mag   <= '0;
            op_q    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            rd_q    <= '0;
            result  <= '0;
            rd_out  <= '0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        op_q    <= funct3;
                        rd_q    <= rd_in;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        b_mag   <= b_mag_in;
                        if (div_zero || div_ovf) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= special_res;
                            rd_out <= rd_in;
                        end else begin
                            state  <= is_div ? DIV : MUL;
                            busy   <= 1'b1;
                            cnt    <= CNT_W'(1);
                            acc_hi <= '0;
                            acc_lo <= a_mag_in;
                        end
                    end
                end
                MUL: begin
                    acc_hi <= prod_next[XLEN2-1:XLEN];
                    acc_lo <= prod_next[XLEN-1:0];
                    if (cnt == CNT_LAST) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        cnt    <= '0;
                        result <= (op_q == 3'b000) ? prod_fin[XLEN-1:0] : prod_fin[XLEN2-1:XLEN];
                        rd_out <= rd_q;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DIV: begin
                    acc_hi <= rem_next;
                    acc_lo <= quo_next;
                    if (cnt == CNT_LAST) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        cnt    <= '0;
                        result <= op_q[1] ? rem_fin : quo_fin;
                        rd_out <= rd_q;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Self-checking bench for rv_muldiv_unit: vector table, random ops against a
// behavioural model, and hand sequences for flush, reset and back-to-back starts.
module tb_rv_muldiv_unit;

    logic        clk, reset, flush, start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    rv_muldiv_unit #(.XLEN(32), .RF_ADDRESS(5)) dut (
        .clk(clk), .reset(reset), .flush(flush), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .busy(busy), .done(done),
        .result(result), .rd_out(rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t e;
    vec_t vecs[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb64, ub;
        logic [63:0]        p;
        logic signed [31:0] qa, qb;
        sa   = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        ub   = {32'b0, b};
        qa   = a;
        qb   = b;
        case (f)
            3'b000: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'b001: begin p = sa * sb64; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return qa / qb;
            end
            3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return qa % qb;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Scoreboard: every done pulse retires the oldest expected result
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done result=%0h rd_out=%0h expected=no_done", result, rd_out);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
            end
        end
    end

    // Called just after a posedge with the unit idle; returns just after a posedge.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int exp_lat);
        int lat, bcnt;
        start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
        sb.push_back('{exp, rd});
        @(posedge clk); #1;
        start = 1'b0; op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
        lat = 0; bcnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin lat = k; break; end
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("busy_cycles", 32'(bcnt), (exp_lat == 1) ? 32'd0 : 32'd32);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, ndone;
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        reset = 1'b1; flush = 1'b0; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;

        vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[2]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'b101, 32'd100,        32'd7,          32'd14,        33};
        vecs[7]  = '{3'b111, 32'd100,        32'd7,          32'd2,         33};
        vecs[8]  = '{3'b101, 32'd17,         32'd0,          32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'b111, 32'd17,         32'd0,          32'd17,        1};
        vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
        vecs[12] = '{3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF, 1};
        vecs[13] = '{3'b110, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 1};
        vecs[14] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[15] = '{3'b100, 32'h8000_0000, 32'd1,          32'h8000_0000, 33};
        vecs[16] = '{3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         33};
        vecs[17] = '{3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vecs[18] = '{3'b010, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 33};
        vecs[19] = '{3'b111, 32'd5,          32'd7,          32'd5,         33};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_rd_out", {27'b0, rd_out}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 20; i++)
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, 5'((i % 31) + 1), vecs[i].exp, vecs[i].lat);

        for (int i = 0; i < 24; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i % 8 == 3) ? 32'd0 : $urandom;
            lat = (rf[2] && (rb == 32'd0 || (!rf[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF))) ? 1 : 33;
            run_op(rf, ra, rb, 5'($urandom), ref_op(rf, ra, rb), lat);
        end

        // Flush mid-multiply: outputs keep the previous op, a new start right after completes
        run_op(3'b000, 32'd2, 32'd3, 5'd9, 32'd6, 33);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd11; op_b = 32'd13; rd_in = 5'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("busy_before_flush", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_done", {31'b0, done}, 32'd0);
        chk("flush_result", result, 32'd6);
        chk("flush_rd_out", {27'b0, rd_out}, 32'd9);
        run_op(3'b000, 32'd11, 32'd13, 5'd12, 32'd143, 33);

        // Flush wins over a same-cycle start of a one-cycle special op
        flush = 1'b1; start = 1'b1; funct3 = 3'b101; op_a = 32'd17; op_b = 32'd0; rd_in = 5'd3;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        chk("flush_prio_done", {31'b0, done}, 32'd0);
        chk("flush_prio_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;

        // Start held high with changing operands while busy, then accepted again in DONE
        start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5; rd_in = 5'd7;
        sb.push_back('{32'd15, 5'd7});
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
        end
        @(posedge clk); #1;
        chk("b2b_first_done", {31'b0, done}, 32'd1);
        funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd11;
        sb.push_back('{32'd14, 5'd11});
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_second_busy", {31'b0, busy}, 32'd1);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin lat = k; break; end
        end
        chk("b2b_latency", 32'(lat), 32'd33);
        @(posedge clk); #1;

        // Reset in the middle of an op discards it
        start = 1'b1; funct3 = 3'b000; op_a = 32'd7; op_b = 32'd9; rd_in = 5'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midreset_busy", {31'b0, busy}, 32'd0);
        chk("midreset_done", {31'b0, done}, 32'd0);
        chk("midreset_result", result, 32'd0);
        chk("midreset_rd_out", {27'b0, rd_out}, 32'd0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midreset_no_done", 32'(ndone), 32'd0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
